i2c_slv_reg_ctrl: RTL
=====================

# i2c_slv_reg_ctrl

Register-file controller behind the I2C slave byte engine. Decodes the address byte, qualifies ACK/NACK, takes the first write byte as a register pointer, and commits later write bytes to a local register bank. It supplies read bytes to the engine on demand and exposes the bank to on-chip logic through a host port. It sequences every I2C transaction that targets the slave; the byte engine only shifts bits.

## Interface
- `SLV_ADDR`, 7'h50, 7-bit slave address to match.
- `AW`, 4, register pointer width; bank holds 2**AW bytes.
- `RST_VAL`, 8'h00, reset value of every bank register.

- `i_sysclk` in 1: system clock; one clock domain, all logic on rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_start` in 1: one-cycle pulse on START or repeated START.
- `i_stop` in 1: one-cycle pulse on STOP.
- `i_rx_valid` in 1: one-cycle pulse when a byte (address or data) has been received.
- `i_rx_data` in 8: received byte; valid with `i_rx_valid`.
- `o_rx_ack` out 1: 1 means ACK the last received byte; engine samples it at the ACK slot.
- `i_tx_req` in 1: one-cycle pulse when the engine needs the next read byte.
- `o_tx_data` out 8: byte to transmit.
- `o_tx_valid` out 1: one-cycle pulse when `o_tx_data` is loaded.
- `i_tx_nack` in 1: one-cycle pulse when the master NACKed the last transmitted byte.
- `i_host_we` in 1: host write enable.
- `i_host_addr` in AW: host register address.
- `i_host_wdata` in 8: host write data.
- `o_host_rdata` out 8: registered `bank[i_host_addr]`.
- `o_busy` out 1: high while an addressed transaction is in progress.
- `o_wr_strobe` out 1: one-cycle pulse when an I2C write commits.
- `o_wr_addr` out AW: register index of that commit.

## Operation
- States: IDLE, ADDR, PTR, WDATA, RDATA, IGNORE.
- IDLE: `i_start` → ADDR.
- ADDR, on `i_rx_valid`:
  - `i_rx_data[7:1]==SLV_ADDR` → `o_rx_ack`=1; bit0=0 → PTR, bit0=1 → RDATA.
  - Mismatch → `o_rx_ack`=0, → IGNORE.
- PTR: `i_rx_valid` → ptr ← `i_rx_data[AW-1:0]` (upper bits discarded), ack=1, → WDATA.
- WDATA: `i_rx_valid` → `bank[ptr]` ← data, `o_wr_strobe`=1, `o_wr_addr`=ptr, ack=1, ptr ← ptr+1.
- RDATA:
  - `i_tx_req` → `o_tx_data` ← `bank[ptr]`, `o_tx_valid`=1, ptr ← ptr+1.
  - `i_tx_nack` → IGNORE.
- IGNORE: `o_rx_ack`=0; no `o_tx_valid`; waits for a bus event.
- Any state:
  - `i_stop` → IDLE.
  - `i_start` → ADDR; ptr retained, so a write-pointer then repeated-START read works.
- Event priority: `i_reset` > `i_stop` > `i_start` > `i_rx_valid`/`i_tx_req`/`i_tx_nack`.
- `i_rx_valid` in RDATA or IDLE, and `i_tx_req` outside RDATA, are ignored; `o_rx_ack`=0.
- Pointer arithmetic: AW bits, wraps from 2**AW-1 to 0.
- Host write and I2C write to the same register in the same cycle: the I2C write wins and the host write is dropped. Otherwise both write independently.
- `o_busy`=1 in PTR, WDATA, RDATA.

## Timing
- `o_rx_ack`: registered, valid 1 cycle after `i_rx_valid`, held until the next `i_rx_valid`/`i_start`/`i_stop`.
- `o_tx_data`/`o_tx_valid`: 1 cycle after `i_tx_req`; `o_tx_data` holds until the next load.
- `o_wr_strobe`/`o_wr_addr`: 1 cycle after `i_rx_valid`; bank updated on the same edge.
- `o_host_rdata`: 1-cycle latency; it reflects same-cycle writes on the following cycle.
- Reset values:
  - Bank all `RST_VAL`; ptr 0; state IDLE.
  - `o_rx_ack` 0, `o_tx_data` 8'hFF, `o_tx_valid` 0, `o_busy` 0, `o_wr_strobe` 0, `o_wr_addr` 0, `o_host_rdata` 0.
- Reset mid-transaction: state returns to IDLE. The bank is restored to `RST_VAL`.
- Back-to-back `i_rx_valid` on consecutive cycles is supported.

## Configuration
- `I2C_SLV_AUTOINC_EN` defined: ptr increments after every WDATA commit and every RDATA load, as above.
- Not defined: ptr changes only in PTR state. Repeated writes and reads all target the same register.

## Test plan
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP → ACK on all four bytes; bank[3]=0x11, bank[4]=0x22; `o_wr_strobe` pulses with `o_wr_addr` 3 then 4.
- Combined read: START, 0xA0, 0x03, rSTART, 0xA1, two `i_tx_req` → `o_tx_data` 0x11 then 0x22; `i_tx_nack` → IGNORE.
- Address mismatch: START, 0xB0, 0x05 → `o_rx_ack`=0 for both bytes; bank unchanged; `o_busy`=0.
- Wrap: pointer 0x0F, write 0xAA, 0xBB → bank[15]=0xAA, bank[0]=0xBB. Without `I2C_SLV_AUTOINC_EN`: bank[15]=0xBB.
- Collision: host writes 0x55 to reg 2 in the same cycle as an I2C commit of 0x66 → bank[2]=0x66; `o_host_rdata`=0x66 one cycle later.
- Reset mid-WDATA → state IDLE, bank all `RST_VAL`, `o_tx_data`=0xFF.

Source files
------------

// File: rtl/i2c_slv_reg_ctrl_if.sv
// rtl/i2c_slv_reg_ctrl_if.sv - byte-engine and host-port bundle for the I2C slave register controller
interface i2c_slv_reg_ctrl_if #(
  parameter int AW = 4
);
  // byte engine side
  logic          i_start;
  logic          i_stop;
  logic          i_rx_valid;
  logic [7:0]    i_rx_data;
  logic          o_rx_ack;
  logic          i_tx_req;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_nack;
  // host side
  logic          i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [7:0]    i_host_wdata;
  logic [7:0]    o_host_rdata;
  logic          o_busy;
  logic          o_wr_strobe;
  logic [AW-1:0] o_wr_addr;

  modport slave (
    input  i_start, i_stop, i_rx_valid, i_rx_data, i_tx_req, i_tx_nack,
    input  i_host_we, i_host_addr, i_host_wdata,
    output o_rx_ack, o_tx_data, o_tx_valid,
    output o_host_rdata, o_busy, o_wr_strobe, o_wr_addr
  );

  modport master (
    output i_start, i_stop, i_rx_valid, i_rx_data, i_tx_req, i_tx_nack,
    output i_host_we, i_host_addr, i_host_wdata,
    input  o_rx_ack, o_tx_data, o_tx_valid,
    input  o_host_rdata, o_busy, o_wr_strobe, o_wr_addr
  );
endinterface

// File: rtl/i2c_slv_reg_ctrl.sv
// rtl/i2c_slv_reg_ctrl.sv - I2C slave transaction sequencer and register bank; I2C_SLV_AUTOINC_EN enables pointer auto-increment
module i2c_slv_reg_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         AW       = 4,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                  i_sysclk,
  input  logic                  i_reset,
  i2c_slv_reg_ctrl_if.slave     bus
);

  localparam int NREG = 2 ** AW;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_PTR    = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rx_ack_q, rx_ack_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    host_rdata_q;
  logic          i2c_we;
  logic          host_we_ok;
  logic [7:0]    bank_q [NREG];

  // Transaction sequencing: bus STOP beats START beats byte-level events.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rx_ack_d    = rx_ack_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    i2c_we      = 1'b0;
    if (bus.i_stop) begin
      state_d  = ST_IDLE;
      rx_ack_d = 1'b0;
    end else if (bus.i_start) begin
      // pointer deliberately kept so a repeated-START read follows a pointer write
      state_d  = ST_ADDR;
      rx_ack_d = 1'b0;
    end else begin
      if (bus.i_rx_valid) begin
        rx_ack_d = 1'b0;
        case (state_q)
          ST_ADDR: begin
            if (bus.i_rx_data[7:1] == SLV_ADDR) begin
              rx_ack_d = 1'b1;
              state_d  = bus.i_rx_data[0] ? ST_RDATA : ST_PTR;
            end else begin
              state_d  = ST_IGNORE;
            end
          end
          ST_PTR: begin
            ptr_d    = bus.i_rx_data[AW-1:0];
            rx_ack_d = 1'b1;
            state_d  = ST_WDATA;
          end
          ST_WDATA: begin
            i2c_we      = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
            rx_ack_d    = 1'b1;
`ifdef I2C_SLV_AUTOINC_EN
            ptr_d       = ptr_q + AW'(1);
`endif
          end
          default: ;
        endcase
      end
      if (state_q == ST_RDATA) begin
        if (bus.i_tx_req) begin
          tx_data_d  = bank_q[ptr_q];
          tx_valid_d = 1'b1;
`ifdef I2C_SLV_AUTOINC_EN
          ptr_d      = ptr_q + AW'(1);
`endif
        end
        if (bus.i_tx_nack) begin
          state_d = ST_IGNORE;
        end
      end
    end
  end

  // A host write to the register the I2C side is committing this cycle is dropped.
  assign host_we_ok = bus.i_host_we && !(i2c_we && (bus.i_host_addr == ptr_q));

  // Control and output registers.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rx_ack_q    <= 1'b0;
      tx_data_q   <= 8'hFF;
      tx_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rx_ack_q    <= rx_ack_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // Register bank with I2C and host write ports; host read is registered.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        bank_q[i] <= RST_VAL;
      end
      host_rdata_q <= 8'h00;
    end else begin
      if (i2c_we) begin
        bank_q[ptr_q] <= bus.i_rx_data;
      end
      if (host_we_ok) begin
        bank_q[bus.i_host_addr] <= bus.i_host_wdata;
      end
      host_rdata_q <= bank_q[bus.i_host_addr];
    end
  end

  assign bus.o_rx_ack     = rx_ack_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_valid   = tx_valid_q;
  assign bus.o_wr_strobe  = wr_strobe_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_host_rdata = host_rdata_q;
  assign bus.o_busy       = (state_q == ST_PTR) || (state_q == ST_WDATA) || (state_q == ST_RDATA);

endmodule
